mult_hilo_ctrl: RTL and testbench

Multi-cycle controller that sequences the combinational 32x32→64 unsigned array multiplier for the MIPS MULT/MULTU instructions and owns the architectural HI/LO registers. It accepts an operand pair from the execute stage and handles signed operands by magnitude conversion and result negation. It holds off the pipeline while the multiplier settles, then writes the 64-bit result to HI/LO. It also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

---
 rtl/mult_hilo_ctrl_pkg.sv | 17 +
 rtl/mult_hilo_ctrl_mul.sv | 12 +
 rtl/mult_hilo_ctrl.sv | 142 ++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared types and constants for the MULT/MULTU HI/LO controller.
package mult_hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADJ  = 2'd2
    } state_t;

    localparam int MUL_CYCLES_MIN = 1;
    localparam int MUL_CYCLES_MAX = 15;
    localparam int CNT_W          = 4;

    localparam int HILO_W = 32;
    localparam int PROD_W = 64;

endpackage

// File: rtl/mult_hilo_ctrl_mul.sv
// Combinational 32x32->64 unsigned array multiplier; result settles over several cycles.
module SixtyFourBitMul
    import mult_hilo_ctrl_pkg::*;
(
    input  logic [HILO_W-1:0] a,
    input  logic [HILO_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    assign p = {{(PROD_W-HILO_W){1'b0}}, a} * {{(PROD_W-HILO_W){1'b0}}, b};

endmodule

// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU sequencer owning HI/LO; serves MTHI/MTLO and MFHI/MFLO stalls.
// Optional build macro MULT_MADD_EN adds the madd port (MADD/MADDU accumulation).
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
`ifdef MULT_MADD_EN
    input  logic              madd,
`endif
    input  logic [HILO_W-1:0] op_a,
    input  logic [HILO_W-1:0] op_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [HILO_W-1:0] wdata,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo
);

    if (MUL_CYCLES < MUL_CYCLES_MIN || MUL_CYCLES > MUL_CYCLES_MAX) begin : g_bad_cycles
        $error("mult_hilo_ctrl: MUL_CYCLES out of range 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic               ld_op, cap, wr;

    logic [HILO_W-1:0]  mag_a_p0, mag_b_p0;
    logic               neg_p0;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  p_reg;
    logic [PROD_W-1:0]  result;
    logic [PROD_W-1:0]  hilo_new;

    logic [HILO_W-1:0]  mag_a, mag_b;

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    assign mag_a = (is_signed && op_a[HILO_W-1]) ? (~op_a + 1'b1) : op_a;
    assign mag_b = (is_signed && op_b[HILO_W-1]) ? (~op_b + 1'b1) : op_b;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        ld_op   = 1'b0;
        cap     = 1'b0;
        wr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ld_op   = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (cnt == '0) begin
                    cap     = 1'b1;
                    state_d = ST_ADJ;
                end
            end
            ST_ADJ: begin
                wr      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready = (state == ST_IDLE);
    assign busy  = ~ready;

    always_ff @(posedge clk) begin
        if (reset)              cnt <= '0;
        else if (ld_op)         cnt <= CNT_LOAD;
        else if (state == ST_MUL && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Stage p0: operand magnitudes and result sign latched on accept.
`ifdef MULT_MADD_EN
    logic madd_p0;
`endif
    always_ff @(posedge clk) begin
        if (ld_op) begin
            mag_a_p0 <= mag_a;
            mag_b_p0 <= mag_b;
            neg_p0   <= is_signed & (op_a[HILO_W-1] ^ op_b[HILO_W-1]);
`ifdef MULT_MADD_EN
            madd_p0  <= madd;
`endif
        end
    end

    SixtyFourBitMul u_mul (
        .a (mag_a_p0),
        .b (mag_b_p0),
        .p (prod)
    );

    // Stage p1: settled product captured once the count expires.
    always_ff @(posedge clk) begin
        if (reset)    p_reg <= '0;
        else if (cap) p_reg <= prod;
    end

    assign result = neg_p0 ? (~p_reg + 1'b1) : p_reg;

`ifdef MULT_MADD_EN
    assign hilo_new = madd_p0 ? ({hi, lo} + result) : result;
`else
    assign hilo_new = result;
`endif

    // Stage p2: architectural HI/LO write and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= wr;
            if (wr) begin
                {hi, lo} <= hilo_new;
            end else if (state == ST_IDLE) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed self-checking bench for mult_hilo_ctrl (MUL_CYCLES=4).
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic        madd;
    logic [31:0] op_a, op_b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        ready, busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.MUL_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
`ifdef MULT_MADD_EN
        .madd      (madd),
`endif
        .op_a      (op_a),
        .op_b      (op_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply; returns edges from accept until done is seen (0 on timeout).
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic m, output int lat);
        op_a = a; op_b = b; is_signed = s; madd = m; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                lat = i - 1;
                break;
            end
            step();
        end
        if (done && lat == 0) lat = 30;
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        step();
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
        end
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
        end
    endtask

    task automatic test_multu_max();
        int lat;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        n_tests++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL multu_max_latency: got %0d, want 5", lat);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max: hi=%h lo=%h, want fffffffe 00000001", hi, lo);
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_done: got %b, want 1", ready);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got %b, want 0", done);
        end
    endtask

    task automatic test_mult_signed();
        int lat;
        do_mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, lat);
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_m3x5: hi=%h lo=%h, want ffffffff fffffff1", hi, lo);
        end
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat);
        n_tests++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL mult_minmin: hi=%h lo=%h, want 40000000 00000000", hi, lo);
        end
        do_mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, lat);
        n_tests++;
        if (hi !== 32'h0000_0004 || lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL multu_fffffffd_x5: hi=%h lo=%h, want 00000004 fffffff1", hi, lo);
        end
    endtask

    task automatic test_mt();
        int lat;
        mt_write(1'b1, 1'b1, 32'hA5A5_0001);
        n_tests++;
        if (hi !== 32'hA5A5_0001 || lo !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL mt_both: hi=%h lo=%h, want a5a50001 a5a50001", hi, lo);
        end
        // MT alongside start: the MT write lands, then the product overwrites it.
        op_a = 32'd3; op_b = 32'd4; is_signed = 1'b0; madd = 1'b0;
        start = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
        step();
        start = 1'b0; mtlo = 1'b0;
        n_tests++;
        if (lo !== 32'h1234_5678 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mt_with_start: lo=%h busy=%b, want 12345678 1", lo, busy);
        end
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        mthi = 1'b0;
        n_tests++;
        if (hi !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL mt_busy_ignored: hi=%h, want a5a50001", hi);
        end
        lat = 0;
        for (int i = 0; i < 20 && !done; i++) step();
        n_tests++;
        if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL mt_then_mul: done=%b hi=%h lo=%h, want 1 0 0000000c", done, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int cyc = 0;
        op_a = 32'd7; op_b = 32'd6; is_signed = 1'b0; madd = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 30) begin
            step();
            cyc++;
        end
        n_tests++;
        if (done !== 1'b1 || cyc !== 5 || lo !== 32'd42 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b lat=%0d lo=%0d hi=%0d, want 1 5 42 0", done, cyc, lo, hi);
        end
        // Start issued in the done cycle must be accepted.
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
        end
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            if (done && lo !== 32'd81) begin
                n_fail++;
                $display("FAIL b2b_second: lo=%0d, want 81", lo);
            end
            step();
        end
        n_tests++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, want 1", ndone);
        end
        n_tests++;
        if (lo !== 32'd81) begin
            n_fail++;
            $display("FAIL b2b_second_final: lo=%0d, want 81", lo);
        end
    endtask

    task automatic test_reset_midflight();
        int ndone = 0;
        mt_write(1'b0, 1'b1, 32'h10);
        n_tests++;
        if (lo !== 32'h10) begin
            n_fail++;
            $display("FAIL mtlo: lo=%h, want 00000010", lo);
        end
        op_a = 32'd2; op_b = 32'd3; is_signed = 1'b0; madd = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h0 || ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: hi=%h lo=%h ready=%b busy=%b, want 0 0 1 0", hi, lo, ready, busy);
        end
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            step();
        end
        n_tests++;
        if (ndone !== 0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_no_done: pulses=%0d lo=%h, want 0 0", ndone, lo);
        end
    endtask

`ifdef MULT_MADD_EN
    task automatic test_madd();
        int lat;
        mt_write(1'b0, 1'b1, 32'h10);
        mt_write(1'b1, 1'b0, 32'h0);
        do_mul(32'd2, 32'd3, 1'b0, 1'b1, lat);
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h16) begin
            n_fail++;
            $display("FAIL maddu: hi=%h lo=%h, want 0 00000016", hi, lo);
        end
        mt_write(1'b1, 1'b1, 32'h0);
        do_mul(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, lat);
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL madd_m1: hi=%h lo=%h, want ffffffff ffffffff", hi, lo);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; madd = 1'b0;
        op_a = '0; op_b = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #2;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_mt();
        step();
        test_back_to_back();
        test_reset_midflight();
`ifdef MULT_MADD_EN
        test_madd();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
